// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the SCPU datapath with load-use hazard detection.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [4:0]      id_ex,
  input  logic [2:0]      id_m,
  input  logic [3:0]      id_wb,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [4:0]      ex_ex,
  output logic [2:0]      ex_m,
  output logic [3:0]      ex_wb,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]     bubble_cnt,
`endif
  output logic            hazard_stall
);

  logic ex_is_load;
  logic uses_rs2;
  logic load_use;
  logic insert_bubble;
  logic capture;

  // A load in EX whose result the ID instruction reads; x0 never creates a dependency.
  // Register operand B or a store both read rs2; others may alias rs2 as an immediate field.
  assign ex_is_load = ex_valid & ex_wb[2] & (ex_wb[1:0] == 2'b11);
  assign uses_rs2   = ~id_ex[4] | id_m[0];
  assign load_use   = id_valid & ex_is_load & (ex_rd != '0)
                    & ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & uses_rs2));

  assign hazard_stall = load_use & ~flush & ~rst;

  // Flush wins over a downstream stall; a hazard bubble only lands when EX can accept.
  assign insert_bubble = flush | (hazard_stall & ~ex_stall);
  assign capture       = ~flush & ~ex_stall & ~hazard_stall;

  // Control path: a bubble zeroes every control bundle so it cannot write or branch.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ex    <= '0;
      ex_m     <= '0;
      ex_wb    <= '0;
    end else if (insert_bubble) begin
      ex_valid <= 1'b0;
      ex_ex    <= '0;
      ex_m     <= '0;
      ex_wb    <= '0;
    end else if (capture) begin
      ex_valid <= id_valid;
      ex_ex    <= id_valid ? id_ex : '0;
      ex_m     <= id_valid ? id_m  : '0;
      ex_wb    <= id_valid ? id_wb : '0;
    end
  end

  // Data path: operands only move on a normal capture and hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
    end else if (capture) begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Free-running bubble count; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (insert_bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
